mem_sync_arbiter: RTL and testbench

Round-robin scheduler that shares a single backing-store transfer port among all per-bank cache-sync engines of the emulated DRAM. Each bank raises a sync request: a writeback of a dirty cache row, or a fill of a new one. The arbiter grants one bank at a time and sequences a fixed-length beat transfer on the shared port. It then returns a one-cycle `done` pulse that drives that bank's `sync` input. It sits beside the per-bank sync array, between the bank state machines and the host/backing-memory interface.

---
 rtl/mem_sync_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_sync_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_arbiter.sv
// mem_sync_arbiter
//   Round-robin scheduler sharing one backing-store transfer port among the
//   per-bank cache-sync engines. One bank is granted at a time. The arbiter
//   runs a BEATS-long beat transfer on the shared port, then pulses done[bank]
//   for one cycle.
//
// Ports
//   clk_i, reset_n_i       single rising-edge clock, synchronous active-low reset
//   req_i[NB]              per-bank sync request (level, held until done)
//   req_wb_i[NB]           per-bank direction, 1 = writeback, 0 = fill
//   req_row_i[NB*ADDR]     per-bank DRAM row, bank i at [i*ADDRWIDTH +: ADDRWIDTH]
//   req_crow_i[NB*CH]      per-bank cache row, packed the same way
//   xfer_valid_o/_ready_i  beat handshake on the shared port
//   xfer_wb_o, xfer_bank_o, xfer_row_o, xfer_crow_o, xfer_beat_o
//                          latched transfer descriptor and current beat index
//   done_o[NB]             one-hot, one-cycle completion pulse
//   busy_o                 high whenever the FSM is not idle
//   dbg_state_o            FSM state (0 idle, 1 xfer, 2 done)
//   dbg_rr_ptr_o           round-robin search start pointer
//
// Handshake: a beat transfers on every rising edge where xfer_valid_o and
// xfer_ready_i are both high. Once raised, valid stays high until the last
// beat is accepted, and every xfer_* output holds still while ready is low.

module mem_sync_arbiter #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int BEATS     = 8,
  localparam int BKW      = BGWIDTH + BAWIDTH,
  localparam int NB       = 2 ** BKW,
  localparam int BTW      = $clog2(BEATS)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [NB-1:0]           req_i,
  input  logic [NB-1:0]           req_wb_i,
  input  logic [NB*ADDRWIDTH-1:0] req_row_i,
  input  logic [NB*CHWIDTH-1:0]   req_crow_i,
  output logic                    xfer_valid_o,
  input  logic                    xfer_ready_i,
  output logic                    xfer_wb_o,
  output logic [BKW-1:0]          xfer_bank_o,
  output logic [ADDRWIDTH-1:0]    xfer_row_o,
  output logic [CHWIDTH-1:0]      xfer_crow_o,
  output logic [BTW-1:0]          xfer_beat_o,
  output logic [NB-1:0]           done_o,
  output logic                    busy_o,
  output logic [1:0]              dbg_state_o,
  output logic [BKW-1:0]          dbg_rr_ptr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [BKW-1:0]         rr_ptr_q;
  logic [NB-1:0]          mask_q;
  logic [BKW-1:0]         bank_q;
  logic                   wb_q;
  logic [ADDRWIDTH-1:0]   row_q;
  logic [CHWIDTH-1:0]     crow_q;
  logic [BTW-1:0]         beat_q;
  logic                   valid_q;
  logic                   busy_q;
  logic [NB-1:0]          done_q;

  // Arbitration result for the current IDLE cycle.
  logic [NB-1:0]          ereq_d;
  logic                   win_found_d;
  logic [BKW-1:0]         win_bank_d;
  logic [BKW-1:0]         scan_idx;

  // Search upward from rr_ptr; the BKW-bit add wraps past NB-1 back to 0.
  // The bank completed in the previous cycle is masked so it cannot be
  // re-granted back-to-back off a still-high request.
  always_comb begin
    ereq_d      = req_i & ~mask_q;
    win_found_d = 1'b0;
    win_bank_d  = '0;
    scan_idx    = '0;
    for (int k = 0; k < NB; k++) begin
      scan_idx = rr_ptr_q + BKW'(k);
      if (!win_found_d && ereq_d[scan_idx]) begin
        win_found_d = 1'b1;
        win_bank_d  = scan_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      mask_q   <= '0;
      bank_q   <= '0;
      wb_q     <= 1'b0;
      row_q    <= '0;
      crow_q   <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          // The mask only ever covers the first IDLE cycle after DONE.
          mask_q <= '0;
          if (win_found_d) begin
            bank_q   <= win_bank_d;
            wb_q     <= req_wb_i[win_bank_d];
            row_q    <= req_row_i[int'(win_bank_d)*ADDRWIDTH +: ADDRWIDTH];
            crow_q   <= req_crow_i[int'(win_bank_d)*CHWIDTH +: CHWIDTH];
            rr_ptr_q <= win_bank_d + BKW'(1);
            beat_q   <= '0;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_XFER;
          end
        end
        S_XFER: begin
          if (xfer_ready_i) begin
            if (beat_q == BTW'(BEATS - 1)) begin
              valid_q <= 1'b0;
              done_q  <= NB'(1) << bank_q;
              state_q <= S_DONE;
            end else begin
              beat_q <= beat_q + BTW'(1);
            end
          end
        end
        S_DONE: begin
          mask_q  <= done_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign xfer_valid_o = valid_q;
  assign xfer_wb_o    = wb_q;
  assign xfer_bank_o  = bank_q;
  assign xfer_row_o   = row_q;
  assign xfer_crow_o  = crow_q;
  assign xfer_beat_o  = beat_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_mem_sync_arbiter.sv
module tb_mem_sync_arbiter;

  localparam int BGWIDTH   = 2;
  localparam int BAWIDTH   = 2;
  localparam int CHWIDTH   = 5;
  localparam int ADDRWIDTH = 17;
  localparam int BEATS     = 8;
  localparam int BKW       = BGWIDTH + BAWIDTH;
  localparam int NB        = 2 ** BKW;
  localparam int BTW       = $clog2(BEATS);

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NB-1:0]           req;
  logic [NB-1:0]           req_wb;
  logic [NB*ADDRWIDTH-1:0] req_row;
  logic [NB*CHWIDTH-1:0]   req_crow;
  logic                    xfer_ready;
  logic                    xfer_valid_o;
  logic                    xfer_wb_o;
  logic [BKW-1:0]          xfer_bank_o;
  logic [ADDRWIDTH-1:0]    xfer_row_o;
  logic [CHWIDTH-1:0]      xfer_crow_o;
  logic [BTW-1:0]          xfer_beat_o;
  logic [NB-1:0]           done_o;
  logic                    busy_o;
  logic [1:0]              dbg_state_o;
  logic [BKW-1:0]          dbg_rr_ptr_o;

  always #5 clk = ~clk;

  mem_sync_arbiter #(
    .BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .CHWIDTH(CHWIDTH),
    .ADDRWIDTH(ADDRWIDTH), .BEATS(BEATS)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_i(req), .req_wb_i(req_wb), .req_row_i(req_row), .req_crow_i(req_crow),
    .xfer_valid_o(xfer_valid_o), .xfer_ready_i(xfer_ready),
    .xfer_wb_o(xfer_wb_o), .xfer_bank_o(xfer_bank_o),
    .xfer_row_o(xfer_row_o), .xfer_crow_o(xfer_crow_o),
    .xfer_beat_o(xfer_beat_o), .done_o(done_o), .busy_o(busy_o),
    .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_errors++;
    if (n_errors <= 40) $display("FAIL %s: event not expected / bound expired", name);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [BKW-1:0]       bank;
    logic                 wb;
    logic [ADDRWIDTH-1:0] row;
    logic [CHWIDTH-1:0]   crow;
  } rec_t;

  rec_t exp_q[$];

  int            cyc = 0;
  int            m_phase = 0;   // 0 waiting, 1 moving beats, 2 completion cycle
  int            m_rr = 0;
  int            m_mask = -1;   // bank skipped in the next arbitration, -1 none
  int            m_bank = 0;
  int            m_beats = 0;
  logic          m_rst = 1'b0;
  logic          e_valid = 1'b0;
  logic          e_busy = 1'b0;
  logic [NB-1:0] e_done = '0;

  always @(posedge clk) begin
    int   w;
    rec_t r;
    cyc++;
    if (!reset_n) begin
      m_phase = 0; m_rr = 0; m_mask = -1; m_beats = 0;
      exp_q.delete();
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      case (m_phase)
        0: begin
          w = -1;
          for (int k = 0; k < NB; k++) begin
            int j;
            j = (m_rr + k) % NB;
            if (req[j] && j != m_mask && w < 0) w = j;
          end
          m_mask = -1;
          if (w >= 0) begin
            r.bank = BKW'(w);
            r.wb   = req_wb[w];
            r.row  = req_row[w*ADDRWIDTH +: ADDRWIDTH];
            r.crow = req_crow[w*CHWIDTH +: CHWIDTH];
            exp_q.push_back(r);
            m_bank  = w;
            m_rr    = (w + 1) % NB;
            m_beats = 0;
            m_phase = 1;
          end
        end
        1: begin
          if (xfer_ready) begin
            m_beats++;
            if (m_beats == BEATS) m_phase = 2;
          end
        end
        default: begin
          m_mask  = m_bank;
          m_phase = 0;
        end
      endcase
    end
    e_valid = (m_phase == 1);
    e_busy  = (m_phase != 0);
    e_done  = (m_phase == 2) ? (NB'(1) << m_bank) : '0;
  end

  // ---------------- monitor / scoreboard ----------------
  int mon_beat = 0;
  logic first_seen = 1'b0;
  int glog_bank[$];
  int glog_wb[$];
  int glog_cyc[$];
  int dlog_cyc[$];
  int rr_at12 = -1;

  initial forever begin
    rec_t r;
    @(negedge clk);
    #1;
    if (m_rst) begin
      chk("rst_valid", 32'(xfer_valid_o), 32'd0);
      chk("rst_busy",  32'(busy_o),       32'd0);
      chk("rst_done",  32'(done_o),       32'd0);
      chk("rst_wb",    32'(xfer_wb_o),    32'd0);
      chk("rst_bank",  32'(xfer_bank_o),  32'd0);
      chk("rst_row",   32'(xfer_row_o),   32'd0);
      chk("rst_crow",  32'(xfer_crow_o),  32'd0);
      chk("rst_beat",  32'(xfer_beat_o),  32'd0);
      mon_beat = 0;
      first_seen = 1'b0;
    end else begin
      chk("valid", 32'(xfer_valid_o), 32'(e_valid));
      chk("busy",  32'(busy_o),       32'(e_busy));
      chk("done",  32'(done_o),       32'(e_done));
      if (xfer_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          note_fail("valid_without_grant");
        end else begin
          r = exp_q[0];
          chk("xfer_bank", 32'(xfer_bank_o), 32'(r.bank));
          chk("xfer_wb",   32'(xfer_wb_o),   32'(r.wb));
          chk("xfer_row",  32'(xfer_row_o),  32'(r.row));
          chk("xfer_crow", 32'(xfer_crow_o), 32'(r.crow));
          chk("xfer_beat", 32'(xfer_beat_o), 32'(mon_beat));
          if (!first_seen) begin
            first_seen = 1'b1;
            glog_bank.push_back(int'(xfer_bank_o));
            glog_wb.push_back(int'(xfer_wb_o));
            glog_cyc.push_back(cyc);
            if (xfer_bank_o == BKW'(12) && rr_at12 < 0) rr_at12 = int'(dbg_rr_ptr_o);
          end
          if (xfer_ready) mon_beat++;
        end
      end
      if (done_o !== '0) begin
        if (exp_q.size() == 0) begin
          note_fail("done_without_grant");
        end else begin
          r = exp_q.pop_front();
          chk("done_onehot", 32'(done_o), 32'(NB'(1) << r.bank));
          chk("done_beats",  32'(mon_beat), 32'(BEATS));
          dlog_cyc.push_back(cyc);
          mon_beat = 0;
          first_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [NB-1:0] keep = '0;
  logic          rand_mode = 1'b0;
  int            ready_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random
  int            pat_cnt = 0;

  task automatic rand_payload(input int i);
    req_wb[i] = 1'($urandom_range(0, 1));
    req_row[i*ADDRWIDTH +: ADDRWIDTH] = ADDRWIDTH'($urandom);
    req_crow[i*CHWIDTH +: CHWIDTH]    = CHWIDTH'($urandom);
  endtask

  task automatic set_req(input int i, input logic wb, input logic [ADDRWIDTH-1:0] row,
                         input logic [CHWIDTH-1:0] crow);
    req_wb[i] = wb;
    req_row[i*ADDRWIDTH +: ADDRWIDTH] = row;
    req_crow[i*CHWIDTH +: CHWIDTH]    = crow;
    req[i] = 1'b1;
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      if (done_o[i] === 1'b1) begin
        if (keep[i] || (rand_mode && $urandom_range(0, 2) == 0)) begin
          if (rand_mode) rand_payload(i);
        end else begin
          req[i] = 1'b0;
        end
      end else if (rand_mode && !req[i] && $urandom_range(0, 9) == 0) begin
        rand_payload(i);
        req[i] = 1'b1;
      end
    end
    // The active bank's inputs may change freely; the latched copy must not.
    if (rand_mode && m_phase == 1) rand_payload(m_bank);
    case (ready_mode)
      0:       xfer_ready = 1'b1;
      1:       begin xfer_ready = (pat_cnt % 3 == 0); pat_cnt++; end
      default: xfer_ready = ($urandom_range(0, 9) < 7);
    endcase
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(req == '0 && m_phase == 0 && exp_q.size() == 0)) begin
      if (n >= budget) begin note_fail("idle_timeout"); return; end
      tick();
      n++;
    end
    tick();
  endtask

  task automatic wait_glog(input int cnt, input int budget);
    int n;
    n = 0;
    while (glog_bank.size() < cnt) begin
      if (n >= budget) begin note_fail("grant_timeout"); return; end
      tick();
      n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    req = '0;
    keep = '0;
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n0;
    int n;
    reset_n    = 1'b0;
    req        = '0;
    req_wb     = '0;
    req_row    = '0;
    req_crow   = '0;
    xfer_ready = 1'b1;
    do_reset(3);

    // Round robin: banks 0, 3, 12 together from rr_ptr = 0.
    n0 = glog_bank.size();
    keep[0] = 1'b1; keep[3] = 1'b1; keep[12] = 1'b1;
    set_req(0, 1'b0, 17'h00100, 5'd1);
    set_req(3, 1'b1, 17'h00300, 5'd3);
    set_req(12, 1'b0, 17'h01200, 5'd12);
    wait_glog(n0 + 5, 200);
    keep = '0;
    wait_idle(200);
    if (glog_bank.size() >= n0 + 5) begin
      chk("rr_order0", 32'(glog_bank[n0]),     32'd0);
      chk("rr_order1", 32'(glog_bank[n0 + 1]), 32'd3);
      chk("rr_order2", 32'(glog_bank[n0 + 2]), 32'd12);
      chk("rr_order3", 32'(glog_bank[n0 + 3]), 32'd0);
      chk("rr_order4", 32'(glog_bank[n0 + 4]), 32'd3);
    end else note_fail("rr_grant_count");
    chk("rr_ptr_after_12", 32'(rr_at12), 32'd13);

    // Single fill request on bank 5.
    n0 = glog_bank.size();
    set_req(5, 1'b0, 17'h1ABCD, 5'd7);
    wait_idle(100);
    if (glog_bank.size() > n0 && dlog_cyc.size() > 0) begin
      chk("single_bank", 32'(glog_bank[n0]), 32'd5);
      chk("single_wb",   32'(glog_wb[n0]),   32'd0);
      chk("single_done_latency", 32'(dlog_cyc[dlog_cyc.size() - 1] - glog_cyc[n0]), 32'(BEATS));
    end else note_fail("single_grant");

    // Backpressure 1,0,0 on a bank 9 writeback.
    ready_mode = 1;
    pat_cnt = 0;
    set_req(9, 1'b1, 17'h0F00D, 5'd21);
    wait_idle(200);
    ready_mode = 0;

    // Mask: bank 2 keeps its request high after done.
    n0 = glog_bank.size();
    keep[2] = 1'b1;
    set_req(2, 1'b0, 17'h00222, 5'd2);
    wait_glog(n0 + 2, 100);
    keep = '0;
    wait_idle(100);
    if (glog_cyc.size() >= n0 + 2)
      chk("mask_regrant_gap", 32'(glog_cyc[n0 + 1] - glog_cyc[n0]), 32'(BEATS + 3));
    else note_fail("mask_grant_count");

    // Reset at beat 3 of a bank 6 transfer, then banks 0 and 9 compete.
    set_req(6, 1'b1, 17'h06666, 5'd6);
    n = 0;
    while (!(xfer_valid_o === 1'b1 && xfer_beat_o == BTW'(3))) begin
      if (n >= 50) begin note_fail("beat3_timeout"); break; end
      tick();
      n++;
    end
    do_reset(2);
    n0 = glog_bank.size();
    set_req(0, 1'b0, 17'h00ABC, 5'd10);
    set_req(9, 1'b0, 17'h09ABC, 5'd19);
    wait_idle(200);
    if (glog_bank.size() >= n0 + 2) begin
      chk("post_reset_first", 32'(glog_bank[n0]),     32'd0);
      chk("post_reset_second", 32'(glog_bank[n0 + 1]), 32'd9);
    end else note_fail("post_reset_grants");

    // Bank 15 writeback, then pointer wraps to bank 0 ahead of bank 14.
    n0 = glog_bank.size();
    set_req(15, 1'b1, 17'h1FFFF, 5'd31);
    wait_glog(n0 + 1, 50);
    set_req(14, 1'b0, 17'h0EEEE, 5'd14);
    set_req(0, 1'b1, 17'h00001, 5'd0);
    wait_idle(200);
    if (glog_bank.size() >= n0 + 3) begin
      chk("dir_bank15", 32'(glog_bank[n0]),     32'd15);
      chk("dir_wb15",   32'(glog_wb[n0]),       32'd1);
      chk("wrap_bank0", 32'(glog_bank[n0 + 1]), 32'd0);
      chk("then_bank14", 32'(glog_bank[n0 + 2]), 32'd14);
    end else note_fail("dir_grants");

    // Randomized traffic with random backpressure.
    rand_mode  = 1'b1;
    ready_mode = 2;
    repeat (3000) tick();
    rand_mode = 1'b0;
    wait_idle(3000);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
